// File: rtl/vec_pkg.sv
// vec_pkg -- op and FSM state encodings shared by vec_alu_stage and its bench.
// Revision 1.0
`default_nettype none

package vec_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_MUL  = 3'd5,
    OP_MAC  = 3'd6,
    OP_PASS = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MULT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/lane_mac.sv
// lane_mac -- combinational W-bit a*b+c, wrapping modulo 2^W.
// Revision 1.0
`default_nettype none

module lane_mac #(
  parameter int W = 16
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] y_o
);

  assign y_o = a_i * b_i + c_i;

endmodule

`default_nettype wire

// File: rtl/vec_alu_stage.sv
// vec_alu_stage -- one-deep vector ALU stage; MUL/MAC share one lane_mac, one lane per cycle.
// Revision 1.0
`default_nettype none

module vec_alu_stage
  import vec_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int regSize = 16,
  parameter int vecSize = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  ctrl,
  input  logic [vecSize-1:0][regSize-1:0]   vect1,
  input  logic [vecSize-1:0][regSize-1:0]   vect2,
  input  logic [vecSize-1:0][regSize-1:0]   vect3,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  ctrlOut,
  output logic [vecSize-1:0][regSize-1:0]   result
);

  localparam int               CNT_W     = (vecSize > 1) ? $clog2(vecSize) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(vecSize - 1);

  state_e                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [WIDTH-1:0]                  ctrl_q, ctrl_d;
  logic [vecSize-1:0][regSize-1:0]   res_q, res_d;
  logic [vecSize-1:0][regSize-1:0]   v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [vecSize-1:0][regSize-1:0]   alu_res;
  logic [regSize-1:0]                mac_c, mac_y;
  op_e                               op_in, op_run;
  logic                              accept, is_mult_op;

  assign in_ready   = reset && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept     = in_valid && in_ready && !flush;
  assign op_in      = op_e'(ctrl[OP_W-1:0]);
  assign op_run     = op_e'(ctrl_q[OP_W-1:0]);
  assign is_mult_op = (op_in == OP_MUL) || (op_in == OP_MAC);

  always_comb begin
    alu_res = '0;
    for (int i = 0; i < vecSize; i++) begin
      case (op_in)
        OP_ADD:  alu_res[i] = vect1[i] + vect2[i];
        OP_SUB:  alu_res[i] = vect1[i] - vect2[i];
        OP_AND:  alu_res[i] = vect1[i] & vect2[i];
        OP_OR:   alu_res[i] = vect1[i] | vect2[i];
        OP_XOR:  alu_res[i] = vect1[i] ^ vect2[i];
        OP_PASS: alu_res[i] = vect3[i];
        default: alu_res[i] = '0;
      endcase
    end
  end

  // The shared multiplier works on the captured operands, lane selected by cnt.
  assign mac_c = (op_run == OP_MAC) ? v3_q[cnt_q] : '0;

  lane_mac #(.W(regSize)) u_lane_mac (
    .a_i (v1_q[cnt_q]),
    .b_i (v2_q[cnt_q]),
    .c_i (mac_c),
    .y_o (mac_y)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    res_d   = res_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      ctrl_d = ctrl;
      v1_d   = vect1;
      v2_d   = vect2;
      v3_d   = vect3;
      cnt_d  = '0;
      if (is_mult_op) begin
        state_d = ST_MULT;
        res_d   = '0;
      end else begin
        state_d = ST_DONE;
        res_d   = alu_res;
      end
    end else begin
      case (state_q)
        ST_MULT: begin
          res_d[cnt_q] = mac_y;
          if (cnt_q == LAST_LANE) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: if (out_ready) state_d = ST_IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ctrl_q  <= '0;
      res_q   <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      v3_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      res_q   <= res_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q;
  assign ctrlOut   = ctrl_q;

endmodule

`default_nettype wire

// File: tb/tb_vec_alu_stage.sv
// tb_vec_alu_stage -- scoreboard bench for vec_alu_stage against a lane-arithmetic model.
// Revision 1.0
`default_nettype none

module tb_vec_alu_stage;

  localparam int W = 8;
  localparam int R = 16;
  localparam int N = 4;

  typedef logic [N-1:0][R-1:0] vec_t;
  typedef struct {
    logic [W-1:0] c;
    vec_t         r;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] ctrl = '0;
  logic [W-1:0] ctrlOut;
  vec_t         vect1 = '0, vect2 = '0, vect3 = '0, result;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic rnd_rdy = 1'b0;
  logic ready_fix = 1'b1;

  vec_alu_stage #(.WIDTH(W), .regSize(R), .vecSize(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .vect1     (vect1),
    .vect2     (vect2),
    .vect3     (vect3),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ctrlOut   (ctrlOut),
    .result    (result)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #2;
    out_ready = rnd_rdy ? ($urandom_range(0, 3) != 0) : ready_fix;
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: each lane computed with wide unsigned arithmetic, then reduced mod 2^R.
  function automatic vec_t model(input logic [W-1:0] c, input vec_t a, input vec_t b, input vec_t d);
    longint unsigned x, y, z, r;
    logic [2:0] op;
    vec_t o;
    op = c[2:0];
    for (int i = 0; i < N; i++) begin
      x = longint'(a[i]);
      y = longint'(b[i]);
      z = longint'(d[i]);
      case (op)
        3'd0:    r = x + y;
        3'd1:    r = x - y;
        3'd2:    r = x & y;
        3'd3:    r = x | y;
        3'd4:    r = x ^ y;
        3'd5:    r = x * y;
        3'd6:    r = x * y + z;
        default: r = z;
      endcase
      o[i] = r[R-1:0];
    end
    return o;
  endfunction

  function automatic vec_t rvec();
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = R'($urandom);
    return v;
  endfunction

  function automatic vec_t splat(input logic [R-1:0] x);
    vec_t v;
    for (int i = 0; i < N; i++) v[i] = x;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [W-1:0] c, input vec_t a, input vec_t b, input vec_t d,
                       output int waited);
    ctrl     = c;
    vect1    = a;
    vect2    = b;
    vect3    = d;
    in_valid = 1'b1;
    waited   = 0;
    forever begin
      @(negedge clk);
      if (in_ready && !flush) break;
      waited++;
      if (waited > 50) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout ctrl=%0h waited=%0d required<=50", c, waited);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    sb.push_back('{c, model(c, a, b, d)});
    #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got ctrlOut=%0h result=%0h required no output", ctrlOut, result);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_result", result, mon_e.r);
        chk("sb_ctrlOut", ctrlOut, mon_e.c);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t a, b, d, full, part;
    int   w;
    logic [2:0] ops3 [3];
    ops3[0] = 3'd0;
    ops3[1] = 3'd2;
    ops3[2] = 3'd3;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_ctrlOut", ctrlOut, 0);
    chk("rst_in_ready", in_ready, 0);
    #2 reset = 1'b1;
    tick();

    // ADD with wrap in the top lane, latency 1
    a[0] = 16'd1; a[1] = 16'd2; a[2] = 16'd3; a[3] = 16'hFFFF;
    b = splat(16'd1);
    issue(8'hA0, a, b, '0, w);
    @(negedge clk);
    chk("add_out_valid", out_valid, 1);
    full[0] = 16'd2; full[1] = 16'd3; full[2] = 16'd4; full[3] = 16'h0000;
    chk("add_result", result, full);
    tick();

    // MAC: lanes fill one per edge, uncomputed lanes read zero
    a[0] = 16'd2; a[1] = 16'd3; a[2] = 16'd4; a[3] = 16'd5;
    issue(8'h36, a, splat(16'd10), splat(16'd1), w);
    full[0] = 16'd21; full[1] = 16'd31; full[2] = 16'd41; full[3] = 16'd51;
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      part = '0;
      for (int j = 0; j < k; j++) part[j] = full[j];
      chk("mac_partial", result, part);
      chk("mac_busy_valid", out_valid, 0);
      chk("mac_busy_ready", in_ready, 0);
      @(posedge clk);
    end
    @(negedge clk);
    chk("mac_out_valid", out_valid, 1);
    chk("mac_result", result, full);
    tick();

    // SUB held under backpressure, then XOR accepted on the releasing edge
    ready_fix = 1'b0;
    issue(8'h01, '0, splat(16'd1), '0, w);
    repeat (5) begin
      @(negedge clk);
      chk("sub_hold_result", result, splat(16'hFFFF));
      chk("sub_hold_valid", out_valid, 1);
      chk("sub_hold_ready", in_ready, 0);
      tick();
    end
    ready_fix = 1'b1;
    issue(8'h44, rvec(), rvec(), rvec(), w);
    chk("xor_same_edge", w, 0);
    @(negedge clk);
    chk("xor_out_valid", out_valid, 1);
    tick();

    // MUL flushed during its second MULT cycle is never presented
    issue(8'h05, rvec(), rvec(), rvec(), w);
    tick();
    flush = 1'b1;
    sb.delete();
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    repeat (6) begin
      @(negedge clk);
      chk("flush_no_result", out_valid, 0);
    end
    tick();

    // Asynchronous reset mid-MULT, then PASS after release
    issue(8'h06, rvec(), rvec(), rvec(), w);
    tick();
    #2 reset = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_result", result, 0);
    chk("arst_in_ready", in_ready, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(negedge clk);
    chk("arst_release_ready", in_ready, 1);
    tick();
    issue(8'h07, rvec(), rvec(), splat(16'd7), w);
    @(negedge clk);
    chk("pass_out_valid", out_valid, 1);
    chk("pass_result", result, splat(16'd7));
    tick();

    // Back-to-back ADD/AND/OR stream
    for (int i = 0; i < 9; i++) begin
      issue({W'($urandom_range(0, 31)) << 3} | W'(ops3[i % 3]), rvec(), rvec(), rvec(), w);
      if (i > 0) chk("b2b_no_stall", w, 0);
    end
    @(negedge clk);
    tick();

    // Randomized ops under random backpressure
    rnd_rdy = 1'b1;
    repeat (150) begin
      issue(W'($urandom), rvec(), rvec(), rvec(), w);
      if ($urandom_range(0, 3) == 0) tick();
    end
    rnd_rdy = 1'b0;
    for (int n = 0; n < 100 && sb.size() != 0; n++) tick();
    chk("drain_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vec_alu_stage.md
VEC_ALU_STAGE -- requirements
Module: vec_alu_stage

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
  WIDTH  8  control word width
  regSize  16  lane width in bits
  vecSize  4  lanes per vector
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low reset
  in_valid  in  1  upstream offers an operation
  in_ready  out  1  stage accepts an operation this cycle
  ctrl  in  WIDTH  control word; ctrl[2:0] = op
  vect1, vect2, vect3  in  vecSize x regSize  operand vectors, packed [vecSize-1:0][regSize-1:0]
  flush  in  1  synchronous abort
  out_valid  out  1  result available
  out_ready  in  1  downstream accepts result
  ctrlOut  out  WIDTH  ctrl captured with the operation
  result  out  vecSize x regSize  lane-wise result
REQ-003 One clock SHALL be used; reset is asynchronous and active-low.

Function
REQ-004 Acceptance SHALL occur on a rising edge where in_valid && in_ready && !flush; ctrl and vect1/2/3 are captured on that edge.
REQ-005 in_ready SHALL be (state==IDLE) || (state==DONE && out_ready); back-to-back accepts are allowed.
REQ-006 Op encoding SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MUL, 110 MAC, 111 PASS.
REQ-007 Per-lane results SHALL be:
  - ADD: v1+v2
  - SUB: v1-v2
  - AND / OR / XOR: bitwise v1, v2
  - MUL: low regSize bits of v1*v2
  - MAC: low regSize bits of v1*v2+v3
  - PASS: v3
  All arithmetic wraps modulo 2^regSize; no saturation, no flags.
REQ-008 FSM states SHALL be IDLE, MULT and DONE.
REQ-009 Single-cycle ops (ADD, SUB, AND, OR, XOR, PASS): IDLE->DONE on accept; result and out_valid are registered on the accept edge (latency 1).
REQ-010 MUL/MAC: IDLE->MULT on accept with lane counter=0; each MULT edge writes lane[cnt] and increments cnt; at cnt==vecSize-1 the FSM goes to DONE (out_valid high after the vecSize-th edge following accept).
REQ-011 In MULT, lanes not yet computed SHALL read 0; out_valid SHALL remain 0 and in_ready SHALL remain 0.
REQ-012 DONE: out_valid=1; result and ctrlOut SHALL hold stable while !out_ready.
REQ-013 DONE with out_ready: a same-edge accept SHALL load the new operation; otherwise the FSM returns to IDLE with out_valid=0.
REQ-014 flush SHALL take priority over all other inputs: next state IDLE, out_valid=0, cnt=0, and any in_valid that cycle is not accepted. result and ctrlOut keep their stale values.
REQ-015 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-016 While reset=0, outputs SHALL be: state=IDLE, cnt=0, out_valid=0, result=0, ctrlOut=0, in_ready=0.
REQ-017 Reset assertion mid-MULT or in DONE SHALL discard the operation immediately; in_ready becomes 1 on the first cycle after reset is released.

Structure
REQ-018 Package vec_pkg SHALL hold the op enum (3 bits), the FSM state enum, and localparam OP_W=3.
REQ-019 One sub-module, lane_mac, SHALL be a combinational regSize-bit (a*b+c) instance. It is instanced once and time-multiplexed across lanes via cnt; MUL drives c=0.

Verification
REQ-020 ADD, vect1 lanes={1,2,3,0xFFFF}, vect2={1,1,1,1}, out_ready=1 -> one cycle later out_valid=1, result={2,3,4,0x0000}.
REQ-021 MAC, v1={2,3,4,5}, v2={10,10,10,10}, v3={1,1,1,1} -> out_valid low for 3 edges and high after the 4th; result={21,31,41,51}; in_ready=0 throughout MULT.
REQ-022 SUB 0-1 with out_ready=0 for 5 cycles -> result lanes 0xFFFF held stable, in_ready=0; out_ready=1 plus a new valid XOR -> accepted on the same edge.
REQ-023 MUL accepted, flush asserted on the 2nd MULT cycle -> next cycle state IDLE, out_valid=0, in_ready=1; the MUL result is never presented.
REQ-024 reset driven to 0 asynchronously mid-MULT (not at a clock edge) -> out_valid=0 and result=0 immediately; after release, a PASS of v3={7,7,7,7} yields {7,7,7,7} one cycle after accept.
REQ-025 Back-to-back ADD, AND, OR streams with out_ready=1 -> one result per cycle, ctrlOut matching each issued ctrl in order.
